// File: rtl/sprite_blitter.sv
// Pixel-serial sprite copy from a synchronous ROM into a 12-bit framebuffer.
// Supports a transparent colour key and clipping at the screen edges.
module sprite_blitter #(
    parameter int unsigned FB_W      = 320,
    parameter int unsigned FB_H      = 240,
    parameter logic [11:0] KEY_COLOR = 12'h0F0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic [9:0]  width,
    input  logic [9:0]  height,
    input  logic [16:0] rom_base,
    output logic [16:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic        fb_we,
    output logic [16:0] fb_addr,
    output logic [11:0] fb_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    state_t      state;
    logic [9:0]  px, py, w, h;
    logic [9:0]  k, j;
    logic        flush_cnt;
    logic        v1, inb1;
    logic [10:0] x1, y1;
    logic [10:0] x_nx, y_nx;
    logic [16:0] addr_nx;

    // Screen coordinates are 11 bits wide so off-screen positions never wrap back on.
    assign x_nx    = {1'b0, px} + {1'b0, k};
    assign y_nx    = {1'b0, py} + {1'b0, j};
    assign addr_nx = 17'(y1) * 17'(FB_W) + 17'(x1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            px        <= '0;
            py        <= '0;
            w         <= '0;
            h         <= '0;
            k         <= '0;
            j         <= '0;
            flush_cnt <= 1'b0;
            v1        <= 1'b0;
            inb1      <= 1'b0;
            x1        <= '0;
            y1        <= '0;
            rom_addr  <= '0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done  <= 1'b0;
            v1    <= 1'b0;
            fb_we <= 1'b0;
            // Stage 2: ROM data for the stage-1 pixel has just arrived.
            if (v1) begin
                fb_we   <= inb1 && (rom_data != KEY_COLOR);
                fb_addr <= addr_nx;
                fb_data <= rom_data;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (width == 10'd0 || height == 10'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            px       <= pos_x;
                            py       <= pos_y;
                            w        <= width;
                            h        <= height;
                            k        <= 10'd1;
                            j        <= 10'd0;
                            rom_addr <= rom_base + 17'd1;
                            busy     <= 1'b1;
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    v1   <= 1'b1;
                    x1   <= x_nx;
                    y1   <= y_nx;
                    inb1 <= (x_nx < 11'(FB_W)) && (y_nx < 11'(FB_H));
                    if (k == w && j == h - 10'd1) begin
                        flush_cnt <= 1'b0;
                        state     <= FLUSH;
                    end else begin
                        rom_addr <= rom_addr + 17'd1;
                        if (k == w) begin
                            k <= 10'd1;
                            j <= j + 10'd1;
                        end else begin
                            k <= k + 10'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: per-cycle comparison against a
// pixel-level model, plus literal checks on the captured write stream.
module tb_sprite_blitter;

    localparam int MAXC = 32;
    localparam int KEY  = 12'h0F0;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  pos_x, pos_y, width, height;
    logic [16:0] rom_base, rom_addr, fb_addr;
    logic [11:0] rom_data, fb_data;
    logic        fb_we, busy, done;

    int errors = 0;
    int checks = 0;
    int key_addr = -1;
    int last_rom = 0;
    int cyc = 0;
    bit active = 0;
    int done_seen;
    int wr_q[$];

    int e_we[MAXC], e_fa[MAXC], e_fd[MAXC];
    int e_busy[MAXC], e_done[MAXC], e_rom[MAXC];

    sprite_blitter dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pos_x(pos_x), .pos_y(pos_y), .width(width), .height(height),
        .rom_base(rom_base), .rom_addr(rom_addr), .rom_data(rom_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .busy(busy), .done(done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [11:0] rom_fn(int a);
        if (a == key_addr) return 12'(KEY);
        return 12'h100 + 12'(a & 255);
    endfunction

    always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // Model: expected outputs per cycle after the start edge.
    task automatic build(int px, int py, int w, int h, int base);
        int n;
        for (int c = 0; c < MAXC; c++) begin
            e_we[c] = 0; e_fa[c] = 0; e_fd[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; e_rom[c] = last_rom;
        end
        if (w == 0 || h == 0) begin
            e_done[1] = 1;
            return;
        end
        n = w * h;
        for (int c = 1; c < MAXC; c++) begin
            e_rom[c] = (c <= n) ? base + c : base + n;
            e_busy[c] = (c <= n + 2) ? 1 : 0;
        end
        e_done[n + 3] = 1;
        for (int p = 0; p < n; p++) begin
            int kk, jj, x, y, a, d;
            kk = p % w + 1;
            jj = p / w;
            x = px + kk;
            y = py + jj;
            a = base + kk + jj * w;
            d = int'(rom_fn(a));
            if (x < 320 && y < 240 && d != KEY) begin
                e_we[p + 3] = 1;
                e_fa[p + 3] = y * 320 + x;
                e_fd[p + 3] = d;
            end
        end
        last_rom = base + n;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (active) begin
            cyc++;
            check("fb_we", int'(fb_we), e_we[cyc]);
            check("busy", int'(busy), e_busy[cyc]);
            check("done", int'(done), e_done[cyc]);
            check("rom_addr", int'(rom_addr), e_rom[cyc]);
            if (e_we[cyc] == 1) begin
                check("fb_addr", int'(fb_addr), e_fa[cyc]);
                check("fb_data", int'(fb_data), e_fd[cyc]);
            end
            if (fb_we) wr_q.push_back(int'(fb_addr));
            if (done) done_seen = cyc;
        end
    end

    task automatic blit(int px, int py, int w, int h, int base,
                        int repulse, int abort_c);
        int total;
        build(px, py, w, h, base);
        total = (w == 0 || h == 0) ? 1 : w * h + 3;
        wr_q.delete();
        done_seen = -1;
        @(negedge clk);
        pos_x = 10'(px); pos_y = 10'(py);
        width = 10'(w); height = 10'(h);
        rom_base = 17'(base);
        start = 1;
        cyc = 0;
        active = 1;
        for (int c = 1; c <= total + 2; c++) begin
            @(negedge clk);
            start = 0;
            if (abort_c != 0 && c == abort_c) begin
                active = 0;
                rst_n = 0;
                #1;
                check("rst_fb_we", int'(fb_we), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_rom_addr", int'(rom_addr), 0);
                @(negedge clk);
                rst_n = 1;
                last_rom = 0;
                return;
            end
            if (repulse != 0 && (c == 3 || c == total)) begin
                start = 1;
                pos_x = 0; pos_y = 0;
                width = 1; height = 1;
                rom_base = 17'd100;
            end
        end
        @(negedge clk);
        start = 0;
        active = 0;
    endtask

    initial begin
        rst_n = 0; start = 0;
        pos_x = 0; pos_y = 0; width = 0; height = 0; rom_base = 0;
        repeat (3) @(negedge clk);
        check("reset_rom_addr", int'(rom_addr), 0);
        check("reset_fb_we", int'(fb_we), 0);
        check("reset_fb_addr", int'(fb_addr), 0);
        check("reset_fb_data", int'(fb_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst_n = 1;
        @(negedge clk);

        // Basic 4x2 blit
        blit(10, 20, 4, 2, 0, 0, 0);
        check("t1_writes", wr_q.size(), 8);
        check("t1_first", wr_q.size() > 0 ? wr_q[0] : -1, 6411);
        check("t1_last", wr_q.size() > 7 ? wr_q[7] : -1, 6734);
        check("t1_done_cyc", done_seen, 11);

        // Colour key at ROM address 3
        key_addr = 3;
        blit(10, 20, 4, 2, 0, 0, 0);
        key_addr = -1;
        check("t2_writes", wr_q.size(), 7);
        check("t2_no_6413", int'(6413 inside {wr_q}), 0);
        check("t2_done_cyc", done_seen, 11);

        // Clipping at the bottom-right corner
        blit(318, 239, 4, 2, 40, 0, 0);
        check("t3_writes", wr_q.size(), 1);
        check("t3_addr", wr_q.size() > 0 ? wr_q[0] : -1, 76799);
        check("t3_done_cyc", done_seen, 11);

        // Zero-size requests
        blit(5, 5, 0, 5, 200, 0, 0);
        check("t4a_writes", wr_q.size(), 0);
        check("t4a_done_cyc", done_seen, 1);
        blit(5, 5, 3, 0, 300, 0, 0);
        check("t4b_writes", wr_q.size(), 0);
        check("t4b_done_cyc", done_seen, 1);

        // start re-pulsed during READ and DONE
        blit(10, 20, 4, 2, 16, 1, 0);
        check("t5_writes", wr_q.size(), 8);
        blit(0, 0, 3, 1, 500, 0, 0);
        check("t5_after_writes", wr_q.size(), 3);
        check("t5_after_first", wr_q.size() > 0 ? wr_q[0] : -1, 1);

        // Reset mid-transfer, then rerun
        blit(10, 20, 4, 2, 0, 0, 4);
        blit(10, 20, 4, 2, 0, 0, 0);
        check("t6_writes", wr_q.size(), 8);
        check("t6_first", wr_q.size() > 0 ? wr_q[0] : -1, 6411);
        check("t6_done_cyc", done_seen, 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
